// File: rtl/byte_packer.sv
// Byte-to-word packer: gathers 8-bit symbols into 32-bit words, first byte in [31:24].
// A last marker closes the stream early and fills the unused lanes with PAD_BYTE.
module byte_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [2:0]  out_bytes,
  output logic [31:0] word_count
);

  logic [23:0] asm_r;
  logic [1:0]  idx_r;
  logic [31:0] out_data_r;
  logic        out_valid_r;
  logic        out_last_r;
  logic [2:0]  out_bytes_r;
  logic [31:0] word_count_r;

  logic        load_ok_s;
  logic        accept_s;
  logic        complete_s;
  logic        drain_s;
  logic [23:0] asm_next_s;
  logic [31:0] word_s;

  // Lane idx takes the incoming byte; lanes above it get the pad value.
  function automatic logic [31:0] build_word(input logic [23:0] asm,
                                             input logic [1:0]  idx,
                                             input logic [7:0]  data);
    logic [31:0] w;
    case (idx)
      2'd0:    w = {data, PAD_BYTE, PAD_BYTE, PAD_BYTE};
      2'd1:    w = {asm[23:16], data, PAD_BYTE, PAD_BYTE};
      2'd2:    w = {asm[23:8], data, PAD_BYTE};
      2'd3:    w = {asm, data};
      default: w = {asm, data};
    endcase
    return w;
  endfunction

  // Accept only when the output register is free this cycle, so a completing byte never stalls.
  always_comb begin
    load_ok_s  = !out_valid_r || out_ready;
    in_ready   = !rst && load_ok_s;
    accept_s   = in_valid && in_ready;
    drain_s    = out_valid_r && out_ready;
    complete_s = accept_s && ((idx_r == 2'd3) || in_last);
    word_s     = build_word(asm_r, idx_r, in_data);
  end

  // Assembly register update for a non-completing byte.
  always_comb begin
    asm_next_s = asm_r;
    if (accept_s && !complete_s) begin
      case (idx_r)
        2'd0:    asm_next_s[23:16] = in_data;
        2'd1:    asm_next_s[15:8]  = in_data;
        2'd2:    asm_next_s[7:0]   = in_data;
        default: asm_next_s        = asm_r;
      endcase
    end else begin
      asm_next_s = asm_r;
    end
  end

  // Byte index and assembly state.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_r <= 24'h000000;
      idx_r <= 2'd0;
    end else if (complete_s) begin
      asm_r <= 24'h000000;
      idx_r <= 2'd0;
    end else if (accept_s) begin
      asm_r <= asm_next_s;
      idx_r <= idx_r + 2'd1;
    end else begin
      asm_r <= asm_r;
      idx_r <= idx_r;
    end
  end

  // Output word register; a load on the drain edge keeps out_valid high with new contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= 32'h00000000;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_bytes_r <= 3'd0;
    end else if (complete_s) begin
      out_data_r  <= word_s;
      out_valid_r <= 1'b1;
      out_last_r  <= in_last;
      out_bytes_r <= {1'b0, idx_r} + 3'd1;
    end else if (drain_s) begin
      out_data_r  <= out_data_r;
      out_valid_r <= 1'b0;
      out_last_r  <= out_last_r;
      out_bytes_r <= out_bytes_r;
    end else begin
      out_data_r  <= out_data_r;
      out_valid_r <= out_valid_r;
      out_last_r  <= out_last_r;
      out_bytes_r <= out_bytes_r;
    end
  end

  // Handed-off word counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count_r <= 32'h00000000;
    end else if (drain_s) begin
      word_count_r <= word_count_r + 32'd1;
    end else begin
      word_count_r <= word_count_r;
    end
  end

  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign out_last   = out_last_r;
  assign out_bytes  = out_bytes_r;
  assign word_count = word_count_r;

endmodule

// File: doc/byte_packer.md
Name: byte_packer

Overview:
Reassembles a stream of 8-bit symbols (e.g. from the Huffman decoder) into 32-bit words. It is the inverse of the compression-side word-to-byte split.
- First byte accepted maps to out_data[31:24], the fourth to out_data[7:0].
- Valid/ready handshake on both sides, with a registered output stage.
- A last marker closes a stream and pads a partial word.

Parameters:
PAD_BYTE, 8'h00, value written into unfilled byte lanes of a word closed early by in_last

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_data  input  8  symbol byte
in_valid  input  1  in_data/in_last valid
in_last  input  1  this byte is the final byte of the stream
in_ready  output  1  packer accepts byte this cycle
out_data  output  32  packed word, byte 0 of word in [31:24]
out_valid  output  1  out_data/out_last/out_bytes valid
out_ready  input  1  downstream accepts word this cycle
out_last  output  1  word contains final byte of stream
out_bytes  output  3  number of real bytes in word, 1..4
word_count  output  32  words handed off since reset

Behaviour:
- Reset (rst=1 at clock edge):
  - Registered state cleared: out_data=0, out_valid=0, out_last=0, out_bytes=0, word_count=0, byte index=0, assembly register=0.
  - in_ready is forced 0 while rst=1.
- Internal state: assembly register (24 bits, bytes 0..2) and byte index idx (0..3).
- load_ok = !out_valid || out_ready.
- in_ready = !rst && load_ok. Bytes are accepted only when the output stage can take a word this cycle, so a completing byte never needs to be held.
- Byte accept when in_valid && in_ready:
  - idx<3 and !in_last: byte stored in lane idx; idx increments.
  - idx==3, or in_last: word formed from assembly lanes 0..idx-1, plus in_data in lane idx, plus PAD_BYTE in lanes idx+1..3.
    - Word loaded into the output register on the same edge.
    - out_valid=1, out_bytes=idx+1, out_last=in_last.
    - idx returns to 0 and the assembly register is cleared to 0.
- Latency: a word is visible on out_* the cycle after its completing byte is accepted. Throughput is 1 byte/cycle sustained when out_ready=1.
- Output handshake (out_valid && out_ready):
  - word_count increments, wrapping from 2^32-1 to 0.
  - out_valid drops next cycle unless a new word loads on the same edge. Load and drain on the same edge keeps out_valid=1 with the new contents.
- Output holds: while out_valid=1 and out_ready=0, out_data, out_last and out_bytes stay stable. in_ready stays 0 and no byte is lost or duplicated.
- Partial words:
  - A partial word (idx>0) without in_last is held indefinitely; there is no timeout.
  - in_last with idx==0 emits a 1-byte word (out_bytes=1).
- After an out_last word, the next accepted byte starts a fresh word at lane 0.
- Reset mid-operation: any partial word and any pending output word are discarded. Nothing is emitted for them.
- in_valid asserted while in_ready=0: the byte is ignored and must be held by the source (no state change).

Test Plan:
1. Bytes F0,FF,0F,F0 on consecutive cycles, out_ready=1 -> one cycle after the 4th accept: out_data=F0FF0FF0, out_bytes=4, out_last=0; word_count=1 after handshake.
2. Bytes AB,CD with in_last on CD -> out_data=ABCD0000, out_bytes=2, out_last=1. Then 11,22,33,44 -> 11223344, out_last=0, proving idx reset.
3. Backpressure: out_ready=0, stream 8 bytes 00..07 -> first word 00010203 held stable and in_ready=0 while it waits. Raise out_ready -> 00010203 then 04050607 in order, word_count=2.
4. Reset mid-word: accept 55,66, pulse rst one cycle, then 11,22,33,44 -> only 11223344 emitted; word_count=1; in_ready=0 during rst.
5. PAD_BYTE=8'hFF, bytes 9A,BC,DE with in_last on DE -> out_data=9ABCDEFF, out_bytes=3, out_last=1. Single byte 77 with in_last -> 77FFFFFF, out_bytes=1.
6. Simultaneous load/drain: continuous bytes with out_ready=1 for 12 bytes -> out_valid pulses once per 4 bytes, no bubbles beyond 1 byte/cycle, word_count=3.
